// File: rtl/uart_tx_mmio_fifo.sv
// uart_tx_mmio_fifo: MMIO byte FIFO that drains into a start/busy UART serializer
module uart_tx_mmio_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy
);
  typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_t;
  localparam logic [PTR_W:0] DEPTH = (PTR_W+1)'(FIFO_DEPTH);
  state_t state, state_d;
  logic [7:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0] count;
  logic ovf, full, empty, busy, push_req, push, pop, clr;
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];
  assign full = count == DEPTH;
  assign empty = count == '0;
  assign push_req = sel & we & (addr == 4'h0);
  assign push = push_req & ~full;
  assign clr = sel & we & (addr == 4'h4) & wdata[3];
  assign pop = (state == IDLE) & ~empty & ~tx_busy;
  assign busy = tx_busy | (state != IDLE);
  assign rdata = (addr == 4'h4) ? {16'h0, 8'(count), 3'b0, empty & ~busy, ovf, busy, empty, full} : '0;
  always_comb begin
    state_d = state;
    state_d = (state == IDLE)    ? (pop ? START : IDLE) :
              (state == START)   ? WAIT_HI :
              (state == WAIT_HI) ? (tx_busy ? WAIT_LO : WAIT_HI) :
                                   (tx_busy ? WAIT_LO : IDLE);
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata[7:0];
  // full is sampled before the pop, so a push at full is dropped even when a pop frees a slot
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      ovf <= 1'b0;
      tx_start <= 1'b0;
      tx_data <= '0;
    end else begin
      state <= state_d;
      tx_start <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        tx_data <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push & ~pop) count <= count + 1'b1;
      else if (pop & ~push) count <= count - 1'b1;
      ovf <= clr ? 1'b0 : (ovf | (push_req & full));
    end
  end
endmodule

// File: tb/tb_uart_tx_mmio_fifo.sv
// tb_uart_tx_mmio_fifo: randomized bench with a queue-based model of the UART TX front end
module tb_uart_tx_mmio_fifo;
  logic clk = 0, rst = 1, sel = 0, we = 0;
  logic [3:0] addr = 0;
  logic [31:0] wdata = 0, rdata;
  logic tx_start, tx_busy;
  logic [7:0] tx_data;
  int checks = 0, failures = 0, pulses = 0, busy_len = 3, ser_cnt = 0;
  bit release_busy = 0;
  logic [7:0] q[$];
  logic m_ovf, m_inflight, m_saw, m_start, m_pop, m_full;
  logic [7:0] m_data;

  uart_tx_mmio_fifo dut (.clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy));

  always #5 clk = ~clk;

  // Model: a byte is in flight from its pop until the serializer's busy has risen and fallen again
  always @(posedge clk) begin
    if (!rst) begin
      checks++;
      if (tx_start !== m_start) begin
        failures++;
        $display("FAIL tx_start_timing got=%b exp=%b t=%0t", tx_start, m_start, $time);
      end
      checks++;
      if (tx_data !== m_data) begin
        failures++;
        $display("FAIL tx_data got=%h exp=%h t=%0t", tx_data, m_data, $time);
      end
      if (tx_start === 1'b1) begin
        pulses++;
        checks++;
        if (tx_busy !== 1'b0) begin
          failures++;
          $display("FAIL start_while_busy tx_busy=%b exp=0 t=%0t", tx_busy, $time);
        end
      end
    end
    if (rst) begin
      q.delete();
      m_ovf = 0; m_inflight = 0; m_saw = 0; m_start = 0; m_data = 0;
      ser_cnt = 0;
      tx_busy <= 1'b0;
    end else begin
      m_full = q.size() == 16;
      m_pop = !m_inflight && q.size() > 0 && !tx_busy;
      if (m_inflight) begin
        if (m_saw && !tx_busy) m_inflight = 0;
        else if (tx_busy) m_saw = 1;
      end
      m_start = m_pop;
      if (m_pop) begin
        m_data = q.pop_front();
        m_inflight = 1;
        m_saw = 0;
      end
      if (sel && we && addr == 4'h0) begin
        if (m_full) m_ovf = 1;
        else q.push_back(wdata[7:0]);
      end
      if (sel && we && addr == 4'h4 && wdata[3]) m_ovf = 0;
      if (tx_start === 1'b1) begin
        tx_busy <= 1'b1;
        ser_cnt = busy_len;
      end else if (tx_busy) begin
        if (release_busy || ser_cnt <= 1) tx_busy <= 1'b0;
        else ser_cnt--;
      end
    end
  end

  function automatic logic [31:0] exp_status();
    logic b, e;
    b = tx_busy | m_inflight;
    e = q.size() == 0;
    return {16'h0, 8'(q.size()), 3'b0, e & !b, m_ovf, b, e, q.size() == 16};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    sel = 1; we = 1; addr = a; wdata = d;
    @(posedge clk); #1;
    sel = 0; we = 0; addr = 0; wdata = 0;
  endtask

  task automatic rd(input logic [3:0] a);
    sel = 1; we = 0; addr = a;
    #1;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!(q.size() == 0 && !m_inflight && tx_busy === 1'b0) && n < 3000) begin cyc(1); n++; end
    checks++;
    if (n >= 3000) begin failures++; $display("FAIL %s_timeout waited=%0d limit=3000", nm, n); end
    rd(4);
    checks++;
    if (rdata !== exp_status()) begin
      failures++;
      $display("FAIL %s_done_status got=%h exp=%h", nm, rdata, exp_status());
    end
  endtask

  task automatic wait_busy(input logic v, input string nm);
    int n = 0;
    while (tx_busy !== v && n < 200) begin cyc(1); n++; end
    checks++;
    if (n >= 200) begin failures++; $display("FAIL %s_busy_wait tx_busy=%b exp=%b", nm, tx_busy, v); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    rd(4);
    checks++;
    if (rdata !== 32'h0000_0012) begin failures++; $display("FAIL reset_status got=%h exp=00000012", rdata); end
    checks++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs tx_start=%b tx_data=%h exp=0/00", tx_start, tx_data);
    end
    rd(0);
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL data_read got=%h exp=0", rdata); end
  endtask

  task automatic test_single();
    busy_len = 10;
    wr(0, 32'h41);
    checks++;
    if (tx_start !== 1'b0) begin failures++; $display("FAIL single_early_start got=%b exp=0", tx_start); end
    cyc(1);
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h41) begin
      failures++;
      $display("FAIL single_start tx_start=%b tx_data=%h exp=1/41", tx_start, tx_data);
    end
    cyc(2);
    rd(4);
    checks++;
    if (rdata[2] !== 1'b1 || rdata[4] !== 1'b0) begin
      failures++;
      $display("FAIL single_busy status=%h exp busy=1 done=0", rdata);
    end
    wait_done("single");
    checks++;
    if (rdata !== 32'h0000_0012) begin failures++; $display("FAIL single_done got=%h exp=00000012", rdata); end
  endtask

  task automatic test_fill_overflow();
    int p0 = pulses;
    busy_len = 2000;
    for (int i = 0; i < 17; i++) wr(0, i);
    rd(4);
    checks++;
    if (rdata !== 32'h0000_1005) begin failures++; $display("FAIL fill_full got=%h exp=00001005", rdata); end
    wr(0, 32'h11);
    rd(4);
    checks++;
    if (rdata !== 32'h0000_100D) begin failures++; $display("FAIL fill_overflow got=%h exp=0000100d", rdata); end
    wr(4, 32'h8);
    rd(4);
    checks++;
    if (rdata !== 32'h0000_1005) begin failures++; $display("FAIL fill_ovf_clear got=%h exp=00001005", rdata); end
    busy_len = 2;
    release_busy = 1;
    cyc(1);
    release_busy = 0;
    wait_done("fill");
    checks++;
    if (pulses - p0 !== 17) begin failures++; $display("FAIL fill_pulses got=%0d exp=17", pulses - p0); end
  endtask

  task automatic test_push_pop();
    int p0 = pulses;
    busy_len = 4;
    for (int i = 0; i < 4; i++) wr(0, 32'h31 + i);
    wait_busy(1'b1, "pp_hi");
    wait_busy(1'b0, "pp_lo");
    cyc(1);
    wr(0, 32'h35);
    rd(4);
    checks++;
    if (rdata[15:8] !== 8'd3 || rdata !== exp_status()) begin
      failures++;
      $display("FAIL push_pop_count status=%h exp=%h count=3", rdata, exp_status());
    end
    checks++;
    if (tx_start !== 1'b1) begin failures++; $display("FAIL push_pop_same_cycle tx_start=%b exp=1", tx_start); end
    wait_done("push_pop");
    checks++;
    if (pulses - p0 !== 5) begin failures++; $display("FAIL push_pop_pulses got=%0d exp=5", pulses - p0); end
  endtask

  task automatic test_reset_mid();
    busy_len = 10;
    for (int i = 0; i < 6; i++) wr(0, 32'h50 + i);
    wait_busy(1'b1, "mid");
    cyc(1);
    rd(4);
    checks++;
    if (rdata[15:8] !== 8'd5 || rdata[2] !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre_reset status=%h exp count=5 busy=1", rdata);
    end
    rst = 1;
    cyc(1);
    rst = 0;
    rd(4);
    checks++;
    if (rdata !== 32'h0000_0012 || tx_start !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset status=%h tx_start=%b exp=00000012/0", rdata, tx_start);
    end
  endtask

  task automatic test_drain8();
    int p0 = pulses;
    for (int i = 0; i < 8; i++) begin
      busy_len = $urandom_range(1, 6);
      wr(0, 32'hA0 + i);
      cyc($urandom_range(0, 3));
    end
    wait_done("drain8");
    checks++;
    if (pulses - p0 !== 8) begin failures++; $display("FAIL drain8_pulses got=%0d exp=8", pulses - p0); end
  endtask

  task automatic test_random();
    logic [3:0] a;
    for (int i = 0; i < 300; i++) begin
      busy_len = $urandom_range(1, 5);
      case ($urandom_range(0, 5))
        0, 1, 2: wr(0, $urandom);
        3: wr(4, $urandom);
        4: wr(4'h8, $urandom);
        default: begin
          a = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h4;
          rd(a);
          checks++;
          if (rdata !== ((a == 4'h4) ? exp_status() : 32'h0)) begin
            failures++;
            $display("FAIL random_read addr=%h got=%h exp=%h", a, rdata, (a == 4'h4) ? exp_status() : 32'h0);
          end
          cyc(1);
        end
      endcase
    end
    wait_done("random");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_push_pop();
    test_reset_mid();
    test_drain8();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
